mem_req_arbiter: RTL

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 29 ++
 rtl/mem_req_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the memory request arbiter.
package mem_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;

    // Request vector bit positions used by the arbiter and the top.
    localparam int REQ_LD = 0;
    localparam int REQ_ST = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: when both requesters are active, the one that
// did not win last time is granted. Grant is combinational and one-hot.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt
);

    // 1 = store won last, so load is preferred; reset value makes load win first.
    logic r_last_st;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_st <= 1'b1;
        end else if (i_update && (|o_gnt)) begin
            r_last_st <= o_gnt[1];
        end
    end

    always_comb begin
        o_gnt = i_req;
        if (&i_req) begin
            o_gnt = r_last_st ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates a load and a store requester onto a single-outstanding bridge,
// with a WAIT-cycle timeout that aborts the transaction and flags xfer_err.
module mem_req_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_gnt,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_data,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_gnt,
    output logic              st_done,
    output logic              xfer_err,
    output logic              br_set_busy,
    output logic [ADDR_W-1:0] br_addr,
    output logic [DATA_W-1:0] br_wdata,
    output logic              br_write,
    input  logic              br_busy,
    input  logic [DATA_W-1:0] br_rdata,
    output logic              arb_busy,
    output arb_state_t        dbg_state
);

    localparam int               CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        r_state, w_state;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_is_st, w_is_st;
    logic              r_ld_gnt, w_ld_gnt;
    logic              r_st_gnt, w_st_gnt;
    logic              r_ld_done, w_ld_done;
    logic              r_st_done, w_st_done;
    logic              r_xfer_err, w_xfer_err;
    logic              r_set_busy, w_set_busy;
    logic              r_br_write, w_br_write;
    logic [ADDR_W-1:0] r_br_addr, w_br_addr;
    logic [DATA_W-1:0] r_br_wdata, w_br_wdata;
    logic [DATA_W-1:0] r_ld_data, w_ld_data;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_update;

    assign w_req = {st_req, ld_req};

    rr_arb2 u_rr_arb2 (
        .i_clk    (HCLK),
        .i_rst_n  (HRESETn),
        .i_req    (w_req),
        .i_update (w_update),
        .o_gnt    (w_gnt)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_is_st    <= 1'b0;
            r_ld_gnt   <= 1'b0;
            r_st_gnt   <= 1'b0;
            r_ld_done  <= 1'b0;
            r_st_done  <= 1'b0;
            r_xfer_err <= 1'b0;
            r_set_busy <= 1'b0;
            r_br_write <= 1'b0;
            r_br_addr  <= '0;
            r_br_wdata <= '0;
            r_ld_data  <= '0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_is_st    <= w_is_st;
            r_ld_gnt   <= w_ld_gnt;
            r_st_gnt   <= w_st_gnt;
            r_ld_done  <= w_ld_done;
            r_st_done  <= w_st_done;
            r_xfer_err <= w_xfer_err;
            r_set_busy <= w_set_busy;
            r_br_write <= w_br_write;
            r_br_addr  <= w_br_addr;
            r_br_wdata <= w_br_wdata;
            r_ld_data  <= w_ld_data;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_is_st    = r_is_st;
        w_ld_gnt   = 1'b0;
        w_st_gnt   = 1'b0;
        w_ld_done  = 1'b0;
        w_st_done  = 1'b0;
        w_xfer_err = 1'b0;
        w_set_busy = 1'b0;
        w_br_write = r_br_write;
        w_br_addr  = r_br_addr;
        w_br_wdata = r_br_wdata;
        w_ld_data  = r_ld_data;
        w_update   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_gnt) begin
                    w_update   = 1'b1;
                    w_state    = ST_WAIT;
                    w_cnt      = '0;
                    w_is_st    = w_gnt[REQ_ST];
                    w_ld_gnt   = w_gnt[REQ_LD];
                    w_st_gnt   = w_gnt[REQ_ST];
                    w_set_busy = 1'b1;
                    w_br_write = w_gnt[REQ_ST];
                    w_br_addr  = w_gnt[REQ_ST] ? st_addr : ld_addr;
                    if (w_gnt[REQ_ST]) begin
                        w_br_wdata = st_data;
                    end
                end
            end
            ST_WAIT: begin
                // br_busy lags br_set_busy by one edge, so the first WAIT cycle (cnt==0) is blind.
                if ((r_cnt != '0) && !br_busy) begin
                    w_state   = ST_RESP;
                    w_ld_done = !r_is_st;
                    w_st_done = r_is_st;
                    if (!r_is_st) begin
                        w_ld_data = br_rdata;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_state    = ST_RESP;
                    w_ld_done  = !r_is_st;
                    w_st_done  = r_is_st;
                    w_xfer_err = 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign ld_gnt      = r_ld_gnt;
    assign st_gnt      = r_st_gnt;
    assign ld_done     = r_ld_done;
    assign st_done     = r_st_done;
    assign xfer_err    = r_xfer_err;
    assign ld_data     = r_ld_data;
    assign br_set_busy = r_set_busy;
    assign br_write    = r_br_write;
    assign br_addr     = r_br_addr;
    assign br_wdata    = r_br_wdata;
    assign arb_busy    = (r_state != ST_IDLE);
    assign dbg_state   = r_state;

endmodule
